multih_sample_player: RTL and testbench

Synthesizable I/Q sample player and symbol-strobe generator for multi-h trellis demodulator bring-up. It replays a RAM-loaded record of I/Q samples at two samples per symbol. It produces the symEnEven/symEn/sym2xEn strobe pattern the trellis expects, with a programmable frame period and strobe offsets. It sits in front of the trellis demodulator in place of the front end, in both simulation and on-board test builds.

---
 rtl/multih_sample_player.sv | 201 ++++++++++++++++++++
 tb/tb_multih_sample_player.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multih_sample_player.sv
// I/Q sample player with symEnEven/symEn/sym2xEn strobe generation for
// multi-h trellis bring-up; optional PN reference via MULTIH_PLAYER_PN_EN.
// Ports: clk, reset (async, active-high); wrEn/wrAddr/wrI/wrQ load the RAM;
// start/stop/loop/lastAddr/framePeriod/secondStart/sampOffset control play;
// iOut/qOut/rdAddr current sample; symEn/sym2xEn/symEnEven strobes;
// busy/done status; refBit PN reference (0 when the macro is undefined).
module multih_sample_player #(
  parameter int SAMPLE_W = 18,
  parameter int ADDR_W   = 12,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wrEn,
  input  logic [ADDR_W-1:0]   wrAddr,
  input  logic [SAMPLE_W-1:0] wrI,
  input  logic [SAMPLE_W-1:0] wrQ,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   lastAddr,
  input  logic [PERIOD_W-1:0] framePeriod,
  input  logic [PERIOD_W-1:0] secondStart,
  input  logic [PERIOD_W-1:0] sampOffset,
  output logic [SAMPLE_W-1:0] iOut,
  output logic [SAMPLE_W-1:0] qOut,
  output logic                symEn,
  output logic                sym2xEn,
  output logic                symEnEven,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rdAddr,
  output logic                refBit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0]   ONE_A = 1;
  localparam logic [PERIOD_W-1:0] ONE_P = 1;

  state_t r_state;
  state_t w_next;

  logic                  r_loop;
  logic [ADDR_W-1:0]     r_last;
  logic [PERIOD_W-1:0]   r_P;
  logic [PERIOD_W-1:0]   r_S;
  logic [PERIOD_W-1:0]   r_H;
  logic [PERIOD_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]     r_fetch;
  logic                  r_lastShown;
  logic [2*SAMPLE_W-1:0] r_ramQ;
  logic [2*SAMPLE_W-1:0] r_mem [2**ADDR_W];

  logic [SAMPLE_W-1:0] r_i;
  logic [SAMPLE_W-1:0] r_q;
  logic [ADDR_W-1:0]   r_rdAddr;
  logic                r_symEn;
  logic                r_sym2x;
  logic                r_even;
  logic                r_done;

  logic                w_go;
  logic                w_run;
  logic                w_s2x;
  logic                w_sym;
  logic                w_even;
  logic [PERIOD_W-1:0] w_sh;
  logic [ADDR_W-1:0]   w_fetchInc;
  logic [ADDR_W-1:0]   w_fetchNext;

  assign w_go = (r_state == S_IDLE) && start && !stop;
  // No strobe once stop is seen or the final sample is already out.
  assign w_run = (r_state == S_RUN) && !stop && !r_lastShown;
  assign w_sh = r_S + r_H;
  assign w_s2x = w_run && ((r_cnt == '0) || (r_cnt == r_H) ||
                           (r_cnt == r_S) || (r_cnt == w_sh));
  assign w_sym = w_run && ((r_cnt == '0) || (r_cnt == r_S));
  assign w_even = w_run && (r_cnt == r_S);

  assign w_fetchInc = (r_loop && (r_fetch == r_last)) ? '0
                                                      : r_fetch + ONE_A;

  // RAM is addressed with the next fetch address so r_ramQ always holds
  // the sample for r_fetch, even with back-to-back strobes.
  always_comb begin
    w_fetchNext = r_fetch;
    if (w_go) begin
      w_fetchNext = '0;
    end else if (w_s2x) begin
      w_fetchNext = w_fetchInc;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_ARM;
      S_ARM:  w_next = S_RUN;
      S_RUN:  if (stop || r_lastShown) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn && !busy) begin
      r_mem[wrAddr] <= {wrI, wrQ};
    end
    r_ramQ <= r_mem[w_fetchNext];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loop      <= 1'b0;
      r_last      <= '0;
      r_P         <= '0;
      r_S         <= '0;
      r_H         <= '0;
      r_cnt       <= '0;
      r_fetch     <= '0;
      r_lastShown <= 1'b0;
      r_i         <= '0;
      r_q         <= '0;
      r_rdAddr    <= '0;
      r_symEn     <= 1'b0;
      r_sym2x     <= 1'b0;
      r_even      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fetch <= w_fetchNext;
      r_symEn <= w_sym;
      r_sym2x <= w_s2x;
      r_even  <= w_even;
      r_done  <= (r_state == S_RUN) && r_lastShown && !stop;
      if (w_go) begin
        r_loop      <= loop;
        r_last      <= lastAddr;
        r_P         <= framePeriod;
        r_S         <= secondStart;
        r_H         <= sampOffset;
        r_lastShown <= 1'b0;
      end
      if (r_state == S_ARM) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= (r_cnt == r_P - ONE_P) ? '0 : r_cnt + ONE_P;
      end
      if (w_s2x) begin
        r_i      <= r_ramQ[2*SAMPLE_W-1:SAMPLE_W];
        r_q      <= r_ramQ[SAMPLE_W-1:0];
        r_rdAddr <= r_fetch;
        if (!r_loop && (r_fetch == r_last)) begin
          r_lastShown <= 1'b1;
        end
      end
    end
  end

`ifdef MULTIH_PLAYER_PN_EN
  logic [16:0] r_lfsr;
  logic        r_ref;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= '0;
      r_ref  <= 1'b0;
    end else if (w_go) begin
      r_lfsr <= 17'h1FFFF;
    end else if (w_sym) begin
      r_ref  <= r_lfsr[0];
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
    end
  end

  assign refBit = r_ref;
`else
  assign refBit = 1'b0;
`endif

  assign iOut      = r_i;
  assign qOut      = r_q;
  assign rdAddr    = r_rdAddr;
  assign symEn     = r_symEn;
  assign sym2xEn   = r_sym2x;
  assign symEnEven = r_even;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_multih_sample_player.sv
// Scoreboard bench for multih_sample_player.
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_multih_sample_player;

  localparam int SW = 18;
  localparam int AW = 12;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wrEn = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [SW-1:0] wrI = '0;
  logic [SW-1:0] wrQ = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] lastAddr = '0;
  logic [PW-1:0] framePeriod = '0;
  logic [PW-1:0] secondStart = '0;
  logic [PW-1:0] sampOffset = '0;
  logic [SW-1:0] iOut;
  logic [SW-1:0] qOut;
  logic          symEn;
  logic          sym2xEn;
  logic          symEnEven;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdAddr;
  logic          refBit;

  multih_sample_player #(
    .SAMPLE_W(SW), .ADDR_W(AW), .PERIOD_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrI(wrI), .wrQ(wrQ),
    .start(start), .stop(stop), .loop(loop), .lastAddr(lastAddr),
    .framePeriod(framePeriod), .secondStart(secondStart),
    .sampOffset(sampOffset),
    .iOut(iOut), .qOut(qOut), .symEn(symEn), .sym2xEn(sym2xEn),
    .symEnEven(symEnEven), .busy(busy), .done(done),
    .rdAddr(rdAddr), .refBit(refBit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [SW-1:0] i;
    logic [SW-1:0] q;
    logic [AW-1:0] a;
    logic        se;
    logic        ev;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          c;
  logic [16:0] m_lfsr = 17'h1FFFF;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    logic b;
    @(negedge clk);
    if (!reset) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if ((symEn && !sym2xEn) || (symEnEven && !symEn)) begin
        chk("strobe_shape", int'({symEn, sym2xEn, symEnEven}), 7);
      end
      if (sym2xEn) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe_addr", int'(rdAddr), -1);
        end else begin
          e = sb.pop_front();
          chk("strobe_time", cyc, e.t);
          chk("iOut", int'(iOut), int'(e.i));
          chk("qOut", int'(qOut), int'(e.q));
          chk("rdAddr", int'(rdAddr), int'(e.a));
          chk("symEn", int'(symEn), int'(e.se));
          chk("symEnEven", int'(symEnEven), int'(e.ev));
        end
        if (symEn) begin
`ifdef MULTIH_PLAYER_PN_EN
          b = m_lfsr[0];
          m_lfsr = {m_lfsr[0] ^ m_lfsr[3], m_lfsr[16:1]};
          chk("refBit_pn", int'(refBit), int'(b));
`else
          b = 1'b0;
          chk("refBit_zero", int'(refBit), int'(b));
`endif
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input int a, input int iv, input int qv);
    @(negedge clk);
    wrEn = 1'b1;
    wrAddr = AW'(a);
    wrI = SW'(iv);
    wrQ = SW'(qv);
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic go(input int la, input logic lp, output int c0);
    @(negedge clk);
    lastAddr = AW'(la);
    loop = lp;
    start = 1'b1;
    m_lfsr = 17'h1FFFF;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Frame slots for P=19, S=9, H=2: cycles 0, 2, 9, 11.
  task automatic push(input int c0, input int j, input int la);
    int offs[4] = '{0, 2, 9, 11};
    int d;
    exp_t e;
    d = j % (la + 1);
    e.t = c0 + 3 + 19 * (j / 4) + offs[j % 4];
    e.i = SW'(d);
    e.q = SW'(-d);
    e.a = AW'(d);
    e.se = (j % 4 == 0) || (j % 4 == 2);
    e.ev = (j % 4 == 2);
    sb.push_back(e);
  endtask

  initial begin
    tick(2);
    chk("rst_data", int'(iOut) | int'(qOut) | int'(rdAddr), 0);
    chk("rst_flags",
        int'({symEn, sym2xEn, symEnEven, busy, done, refBit}), 0);
    reset = 1'b0;
    framePeriod = 8'd19;
    secondStart = 8'd9;
    sampOffset = 8'd2;
    for (int n = 0; n < 10; n++) wr(n, n, -n);

    go(9, 1'b0, c);
    for (int j = 0; j < 10; j++) push(c, j, 9);
    wait_to(c + 4);
    wrEn = 1'b1;
    wrAddr = AW'(3);
    wrI = SW'(777);
    wrQ = SW'(777);
    tick(1);
    wrEn = 1'b0;
    wait_to(c + 43);
    chk("t1_busy_last", int'(busy), 1);
    tick(1);
    chk("t1_busy_fall", int'(busy), 0);
    tick(5);
    chk("t1_done_cyc", done_cyc, c + 44);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_iOut_hold", int'(iOut), 9);

    go(9, 1'b1, c);
    for (int j = 0; j < 25; j++) push(c, j, 9);
    wait_to(c + 117);
    stop = 1'b1;
    tick(1);
    chk("t2_busy_stop", int'(busy), 0);
    stop = 1'b0;
    tick(10);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_rdAddr", int'(rdAddr), 4);

    go(9, 1'b0, c);
    push(c, 0, 9);
    push(c, 1, 9);
    wait_to(c + 8);
    stop = 1'b1;
    chk("t3_busy_pre", int'(busy), 1);
    tick(1);
    chk("t3_busy_post", int'(busy), 0);
    stop = 1'b0;
    tick(20);
    chk("t3_iOut_hold", int'(iOut), 1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_sb_empty", sb.size(), 0);

    start = 1'b1;
    stop = 1'b1;
    tick(5);
    chk("t4_tie_idle", int'(busy), 0);
    start = 1'b0;
    stop = 1'b0;
    tick(3);

    go(9, 1'b1, c);
    for (int j = 0; j < 3; j++) push(c, j, 9);
    wait_to(c + 12);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_data", int'(iOut) | int'(qOut) | int'(rdAddr), 0);
    chk("t5_rst_flags",
        int'({symEn, sym2xEn, symEnEven, busy, done, refBit}), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("t5_sb_empty", sb.size(), 0);
    tick(2);
    go(2, 1'b0, c);
    for (int j = 0; j < 3; j++) push(c, j, 2);
    wait_to(c + 20);
    chk("t5_done_cyc", done_cyc, c + 13);
    chk("t5_done_cnt", done_cnt, 2);
    chk("t5_sb_empty2", sb.size(), 0);

    go(0, 1'b1, c);
    for (int j = 0; j < 80; j++) push(c, j, 0);
    wait_to(c + 376);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(10);
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_done_cnt", done_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
